stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Pipeline stall controller; it is the producer of the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Stall bit mapping: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- Merges the ID load-use request, the EX level request and a multi-cycle EX operation sequencer (madd/msub/div) into one stall vector.
- Also keeps a stall-cycle statistic and a watchdog flag.

Parameters:
- CNT_W, 6, width of multi-cycle length and down-counter.
- STAT_W, 32, width of stall statistic counter.
- TIMEOUT, 1023, consecutive stall cycles before stall_timeout sets.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset. Asynchronous, active-low: 0 resets all state immediately.
- stallreq_from_id  in  1  ID load-use hazard request, level.
- stallreq_from_ex  in  1  EX generic stall request, level.
- ex_mc_start  in  1  one-cycle pulse: EX begins multi-cycle op.
- ex_mc_cycles  in  CNT_W  op length N, sampled with ex_mc_start.
- ex_mc_cancel  in  1  abort current multi-cycle op (flush).
- ex_mc_busy  out  1  sequencer in BUSY.
- ex_mc_done  out  1  last stall cycle of op; EX result valid this cycle.
- stall  out  6  stall vector to pipeline registers (combinational).
- stall_cycles  out  STAT_W  count of cycles with stall!=0.
- stall_timeout  out  1  sticky watchdog flag.
- timeout_clr  in  1  clears stall_timeout and watchdog count.

Behaviour:
- Reset values (rst=0, async): FSM IDLE, cnt=0, ex_mc_busy=0, ex_mc_done=0, stall=6'b000000, stall_cycles=0, stall_timeout=0, watchdog count 0.
- FSM states: IDLE and BUSY. cnt is the remaining stall cycles including the current one.
- IDLE + ex_mc_start, N>=2: stall asserted in the start cycle T. Next edge enters BUSY with cnt=N-1.
- IDLE + ex_mc_start, N<=1: stall only in cycle T. ex_mc_done=1 in T. Stays IDLE.
- BUSY: stall asserted every cycle. Each edge decrements cnt. ex_mc_done=1 when cnt==1; on that edge → IDLE.
- Net effect: stall held exactly max(N,1) cycles T..T+max(N,1)-1. ex_mc_done fires in the final one only.
- ex_mc_start while BUSY is ignored. No queueing, count unaffected.
- ex_mc_cancel while BUSY: stall from the sequencer drops in the same cycle, ex_mc_done=0, next edge → IDLE, cnt=0. Cancel in IDLE has no effect.
- Cancel and start in the same IDLE cycle: cancel wins, start ignored, no stall.
- ex_mc_busy = (state==BUSY) or (IDLE and ex_mc_start and N>=2 and not cancel).
- ex_stall = stallreq_from_ex or sequencer stall.
- stall encoding, priority order:
  - ex_stall → 6'b001111 (PC, IF, ID, EX held; EX/MEM receives bubble).
  - else stallreq_from_id → 6'b000111 (ID/EX receives bubble).
  - else 6'b000000.
- stall is purely combinational from current state and inputs, with zero latency to the pipeline registers. No other output depends combinationally on stall.
- stall_cycles: increments each edge where stall!=0. Saturates at all-ones, no wrap.
- Watchdog:
  - Counts consecutive cycles with stall!=0; resets to 0 on any cycle with stall==0.
  - When the count reaches TIMEOUT, stall_timeout sets on that edge and stays set.
  - timeout_clr has priority over set in the same cycle: clears the flag and the count.
- Reset asserted mid-op: everything returns to reset values immediately. stall drops asynchronously to 0 while rst=0.

Test Plan:
- Reset: rst=0 with stallreq_from_ex=1 → stall=0, all counters 0. Release rst → stall=6'b001111 in the same cycle.
- ID hazard: stallreq_from_id=1 for 2 cycles → stall=6'b000111 for exactly 2 cycles, stall_cycles=2. Assert stallreq_from_ex concurrently → stall=6'b001111.
- Multi-cycle op: ex_mc_start with ex_mc_cycles=5 at T → stall=6'b001111 T..T+4, ex_mc_done only at T+4, busy T..T+4, stall=0 at T+5. N=1 and N=0 → one stall cycle with done in T. Start again at T+2 → ignored, done still at T+4.
- Cancel: N=10, cancel at T+3 → stall=0 and done=0 at T+3, IDLE at T+4, stall_cycles=3. Cancel together with start in IDLE → no stall.
- Watchdog: TIMEOUT=8, stallreq_from_ex held 8 cycles → stall_timeout=1 after 8th edge, stays after release. timeout_clr pulse → 0. Holding 7 cycles, 1 idle cycle, 7 cycles → never sets.
- Saturation: STAT_W=4, 20 stall cycles → stall_cycles=15.

Source files
------------

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests and a multi-cycle EX
// sequencer into the 6-bit stall vector, with a stall statistic and a watchdog.
module stall_ctrl #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned STAT_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              ex_mc_cancel,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic [5:0]        stall,
  output logic [STAT_W-1:0] stall_cycles,
  output logic              stall_timeout,
  input  logic              timeout_clr
);

  localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_NONE = 6'b000000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STAT_W-1:0]   stat_q, stat_d;
  logic [WD_W-1:0]     wd_q, wd_d, wd_inc;
  logic                to_q, to_d;

  logic                seq_stall;
  logic                mc_busy;
  logic                mc_done;
  logic                ex_stall;
  logic [5:0]          stall_raw;
  logic                stall_any;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state and outputs; cnt counts remaining stall cycles incl. current
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_stall = 1'b0;
    mc_busy   = 1'b0;
    mc_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_mc_start && !ex_mc_cancel) begin
          seq_stall = 1'b1;
          if (ex_mc_cycles >= CNT_W'(2)) begin
            mc_busy = 1'b1;
            state_d = S_BUSY;
            cnt_d   = ex_mc_cycles - CNT_W'(1);
          end else begin
            mc_done = 1'b1;
          end
        end
      end
      S_BUSY: begin
        mc_busy = 1'b1;
        if (ex_mc_cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          seq_stall = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            mc_done = (cnt_q == CNT_W'(1));
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall encoding; gated by reset so the vector drops asynchronously
  always_comb begin
    ex_stall = stallreq_from_ex || seq_stall;
    if (ex_stall) begin
      stall_raw = STALL_EX;
    end else if (stallreq_from_id) begin
      stall_raw = STALL_ID;
    end else begin
      stall_raw = STALL_NONE;
    end
  end

  assign stall      = rst ? stall_raw : STALL_NONE;
  assign ex_mc_busy = rst & mc_busy;
  assign ex_mc_done = rst & mc_done;
  assign stall_any  = (stall != STALL_NONE);

  // Saturating stall statistic and consecutive-stall watchdog
  always_comb begin
    stat_d = stat_q;
    if (stall_any && (stat_q != {STAT_W{1'b1}})) begin
      stat_d = stat_q + STAT_W'(1);
    end
    wd_inc = (wd_q == WD_W'(TIMEOUT)) ? wd_q : (wd_q + WD_W'(1));
    wd_d   = wd_q;
    to_d   = to_q;
    if (timeout_clr) begin
      wd_d = '0;
      to_d = 1'b0;
    end else if (!stall_any) begin
      wd_d = '0;
    end else begin
      wd_d = wd_inc;
      if (wd_inc == WD_W'(TIMEOUT)) begin
        to_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
      wd_q   <= '0;
      to_q   <= 1'b0;
    end else begin
      stat_q <= stat_d;
      wd_q   <= wd_d;
      to_q   <= to_d;
    end
  end

  assign stall_cycles  = stat_q;
  assign stall_timeout = to_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: a default-parameter instance and
// a small one (STAT_W=4, TIMEOUT=8) driven by the same stimulus.
module tb_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       stallreq_from_id;
  logic       stallreq_from_ex;
  logic       ex_mc_start;
  logic [5:0] ex_mc_cycles;
  logic       ex_mc_cancel;
  logic       timeout_clr;

  logic        busy, done, tmo;
  logic [5:0]  stall;
  logic [31:0] scyc;
  logic        s_busy, s_done, s_tmo;
  logic [5:0]  s_stall;
  logic [3:0]  s_scyc;

  int n_checks = 0;
  int n_errors = 0;

  stall_ctrl u_dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .ex_mc_start      (ex_mc_start),
    .ex_mc_cycles     (ex_mc_cycles),
    .ex_mc_cancel     (ex_mc_cancel),
    .ex_mc_busy       (busy),
    .ex_mc_done       (done),
    .stall            (stall),
    .stall_cycles     (scyc),
    .stall_timeout    (tmo),
    .timeout_clr      (timeout_clr)
  );

  stall_ctrl #(.CNT_W(6), .STAT_W(4), .TIMEOUT(8)) u_small (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .ex_mc_start      (ex_mc_start),
    .ex_mc_cycles     (ex_mc_cycles),
    .ex_mc_cancel     (ex_mc_cancel),
    .ex_mc_busy       (s_busy),
    .ex_mc_done       (s_done),
    .stall            (s_stall),
    .stall_cycles     (s_scyc),
    .stall_timeout    (s_tmo),
    .timeout_clr      (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b0;
    ex_mc_start      = 1'b0;
    ex_mc_cycles     = 6'd0;
    ex_mc_cancel     = 1'b0;
    timeout_clr      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset with EX request held
    clear_inputs();
    rst = 1'b0;
    stallreq_from_ex = 1'b1;
    #3;
    check("rst_stall", 32'(stall), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    tick();
    check("rst_scyc", scyc, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_stall", 32'(stall), 32'h0f);
    stallreq_from_ex = 1'b0;
    #1;
    check("rel_stall_off", 32'(stall), 32'h00);
    tick();
    check("rel_scyc", scyc, 32'd0);

    // ID hazard for two cycles, then ID+EX together
    do_reset();
    stallreq_from_id = 1'b1;
    #1;
    check("id_stall_c1", 32'(stall), 32'h07);
    tick();
    #1;
    check("id_stall_c2", 32'(stall), 32'h07);
    tick();
    stallreq_from_id = 1'b0;
    #1;
    check("id_stall_off", 32'(stall), 32'h00);
    check("id_scyc", scyc, 32'd2);
    stallreq_from_id = 1'b1;
    stallreq_from_ex = 1'b1;
    #1;
    check("idex_prio", 32'(stall), 32'h0f);
    tick();
    clear_inputs();
    #1;
    check("idex_scyc", scyc, 32'd3);

    // Multi-cycle N=5, with an ignored start in the third cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ex_mc_start  = (i == 0) || (i == 2);
      ex_mc_cycles = (i == 2) ? 6'd3 : 6'd5;
      #1;
      check("mc5_stall", 32'(stall), 32'h0f);
      check("mc5_busy", 32'(busy), 32'd1);
      check("mc5_done", 32'(done), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    clear_inputs();
    #1;
    check("mc5_end_stall", 32'(stall), 32'h00);
    check("mc5_end_busy", 32'(busy), 32'd0);
    check("mc5_end_done", 32'(done), 32'd0);
    check("mc5_scyc", scyc, 32'd5);

    // N=1 and N=0: single stall cycle with done
    do_reset();
    for (int n = 1; n >= 0; n--) begin
      ex_mc_start  = 1'b1;
      ex_mc_cycles = 6'(n);
      #1;
      check("mcs_stall", 32'(stall), 32'h0f);
      check("mcs_done", 32'(done), 32'd1);
      check("mcs_busy", 32'(busy), 32'd0);
      tick();
      clear_inputs();
      #1;
      check("mcs_after", 32'(stall), 32'h00);
      check("mcs_after_busy", 32'(busy), 32'd0);
    end
    check("mcs_scyc", scyc, 32'd2);

    // Cancel N=10 in its fourth cycle
    do_reset();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("cx_stall", 32'(stall), 32'h0f);
      tick();
      ex_mc_start = 1'b0;
    end
    ex_mc_cancel = 1'b1;
    #1;
    check("cx_cancel_stall", 32'(stall), 32'h00);
    check("cx_cancel_done", 32'(done), 32'd0);
    check("cx_cancel_busy", 32'(busy), 32'd1);
    tick();
    ex_mc_cancel = 1'b0;
    #1;
    check("cx_idle_busy", 32'(busy), 32'd0);
    check("cx_idle_stall", 32'(stall), 32'h00);
    check("cx_scyc", scyc, 32'd3);
    // Cancel and start together in IDLE
    ex_mc_cancel = 1'b1;
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd4;
    #1;
    check("cs_stall", 32'(stall), 32'h00);
    check("cs_busy", 32'(busy), 32'd0);
    check("cs_done", 32'(done), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("cs_busy_after", 32'(busy), 32'd0);
    check("cs_scyc", scyc, 32'd3);

    // Watchdog on the TIMEOUT=8 instance
    do_reset();
    stallreq_from_ex = 1'b1;
    repeat (7) tick();
    check("wd_7", 32'(s_tmo), 32'd0);
    tick();
    check("wd_8", 32'(s_tmo), 32'd1);
    stallreq_from_ex = 1'b0;
    tick();
    check("wd_sticky", 32'(s_tmo), 32'd1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("wd_clr", 32'(s_tmo), 32'd0);
    // 7 on, 1 off, 7 on never reaches 8
    do_reset();
    stallreq_from_ex = 1'b1;
    repeat (7) tick();
    stallreq_from_ex = 1'b0;
    tick();
    stallreq_from_ex = 1'b1;
    repeat (7) tick();
    check("wd_gap", 32'(s_tmo), 32'd0);
    tick();
    check("wd_gap_8th", 32'(s_tmo), 32'd1);
    // Clear wins over set and restarts the count
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("wd_clr_prio", 32'(s_tmo), 32'd0);
    repeat (7) tick();
    check("wd_recount_7", 32'(s_tmo), 32'd0);
    tick();
    check("wd_recount_8", 32'(s_tmo), 32'd1);

    // Statistic saturation on the 4-bit instance
    do_reset();
    stallreq_from_ex = 1'b1;
    repeat (15) tick();
    check("sat_15", 32'(s_scyc), 32'd15);
    repeat (5) tick();
    check("sat_20", 32'(s_scyc), 32'd15);
    check("nosat_20", scyc, 32'd20);

    // Default TIMEOUT=1023 boundary
    do_reset();
    stallreq_from_ex = 1'b1;
    repeat (1022) tick();
    check("wd1023_1022", 32'(tmo), 32'd0);
    tick();
    check("wd1023_1023", 32'(tmo), 32'd1);
    clear_inputs();

    // Reset asserted mid-op
    do_reset();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd10;
    tick();
    ex_mc_start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rmid_stall", 32'(stall), 32'h00);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_scyc", scyc, 32'd0);
    rst = 1'b1;
    #1;
    check("rmid_rel_stall", 32'(stall), 32'h00);
    check("rmid_rel_busy", 32'(busy), 32'd0);
    tick();
    check("rmid_rel_scyc", scyc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
